// File: rtl/conv2d_stream.sv
// ---------------------------------------------------------------------------
// conv2d_stream
//
// Streaming 3x3 "valid"-padding correlation over a raster-scan pixel stream.
// Two IMG_W-deep line buffers supply the two previous rows. A 3x3 window
// register is shifted one column per accepted pixel. A host-writable signed
// 3x3 kernel is applied one clock after the window fills, which gives two
// pipeline stages.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous, active-high reset
//   pixel_in     8-bit unsigned pixel, raster order
//   pixel_valid  pixel_in is accepted on this edge when high
//   coef_we      kernel coefficient write strobe
//   coef_addr    coefficient index k = 3*r + c (values 9..15 are ignored)
//   coef_data    8-bit signed coefficient
//   conv_out     32-bit signed result; holds its value between strobes
//   valid        one-cycle strobe marking a new conv_out
//   frame_done   pulses together with the valid for the last window of a frame
// ---------------------------------------------------------------------------
module conv2d_stream #(
    parameter int IMG_W = 5,
    parameter int IMG_H = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic [31:0] conv_out,
    output logic        valid,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Line buffers. Element IMG_W-1 is the pixel directly above the incoming
    // one (lb1) and the pixel two rows above it (lb2).
    logic [7:0] lb1_q [IMG_W];
    logic [7:0] lb1_d [IMG_W];
    logic [7:0] lb2_q [IMG_W];
    logic [7:0] lb2_d [IMG_W];

    // Window, flattened as k = 3*r + c. r=0 is the oldest row and c=0 is the
    // oldest column, so it lines up directly with coefficient index k.
    logic [7:0] win_q [9];
    logic [7:0] win_d [9];

    // Stage-1 flags: the window register now holds a complete window.
    logic win_ok_q, win_ok_d;
    logic win_last_q, win_last_d;

    // Kernel store.
    logic signed [7:0] coef_q [9];
    logic signed [7:0] coef_d [9];

    // Stage-2 outputs.
    logic [31:0] conv_out_q, conv_out_d;
    logic        valid_q, valid_d;
    logic        frame_done_q, frame_done_d;

    logic accept;

    // Datapath products and their sum.
    logic signed [16:0] prod [9];
    logic signed [20:0] sum;

    // rst masks pixel_valid. Without this mask, the un-reset line buffers and
    // window would still shift on a reset edge.
    assign accept = pixel_valid && !rst;

    // -----------------------------------------------------------------------
    // Stage 1: counters, line buffers, window, completion flags
    // -----------------------------------------------------------------------
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        lb1_d      = lb1_q;
        lb2_d      = lb2_q;
        win_d      = win_q;
        win_ok_d   = 1'b0;
        win_last_d = 1'b0;

        if (accept) begin
            win_ok_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
            win_last_d = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            lb1_d[0] = pixel_in;
            lb2_d[0] = lb1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1_d[i] = lb1_q[i-1];
                lb2_d[i] = lb2_q[i-1];
            end

            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb2_q[IMG_W-1];
            win_d[5] = lb1_q[IMG_W-1];
            win_d[8] = pixel_in;
        end
    end

    // -----------------------------------------------------------------------
    // Kernel store. A write on the same edge that completes a window is still
    // seen by that window, because the sum is formed one edge later.
    // -----------------------------------------------------------------------
    always_comb begin
        coef_d = coef_q;
        if (coef_we && !rst) begin
            for (int k = 0; k < 9; k++) begin
                if (coef_addr == 4'(k)) begin
                    coef_d[k] = coef_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: multiply-accumulate
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_mul
            // Zero-extend the pixel so that 255 stays positive.
            assign prod[gi] = $signed({1'b0, win_q[gi]}) * coef_q[gi];
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + {{4{prod[k][16]}}, prod[k]};
        end
    end

    always_comb begin
        valid_d      = win_ok_q;
        frame_done_d = win_ok_q && win_last_q;
        conv_out_d   = win_ok_q ? {{11{sum[20]}}, sum} : conv_out_q;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_ok_q     <= 1'b0;
            win_last_q   <= 1'b0;
            conv_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                coef_q[k] <= 8'sd1;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_ok_q     <= win_ok_d;
            win_last_q   <= win_last_d;
            conv_out_q   <= conv_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            coef_q       <= coef_d;
        end
    end

    // Pixel storage is not reset. The row/col gating keeps stale contents
    // from ever reaching an output.
    always_ff @(posedge clk) begin
        lb1_q <= lb1_d;
        lb2_q <= lb2_d;
        win_q <= win_d;
    end

    assign conv_out   = conv_out_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

    localparam int W = 5;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic [31:0] conv_out;
    logic        valid;
    logic        frame_done;

    conv2d_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .conv_out   (conv_out),
        .valid      (valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [31:0] val;
        bit          last;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          fd_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          nvalid = 0;
    logic [31:0] last_exp = '0;
    bit          mon_en = 1'b0;

    // Reference model state
    int img [H][W];
    int kern [9];
    int mrow = 0;
    int mcol = 0;

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid === 1'b1) begin
                exp_t e;
                nvalid++;
                total++;
                assert (sbq.size() > 0) else begin
                    bad++;
                    $error("FAIL extra_valid: conv_out=%0d at cycle %0d, required no valid", $signed(conv_out), cnt);
                end
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    last_exp = e.val;
                    total++;
                    assert (conv_out === e.val) else begin
                        bad++;
                        $error("FAIL conv_out: got %0d, required %0d", $signed(conv_out), $signed(e.val));
                    end
                    total++;
                    assert (cnt == e.cyc + 2) else begin
                        bad++;
                        $error("FAIL latency: valid at cycle %0d, required %0d", cnt, e.cyc + 2);
                    end
                    total++;
                    assert (frame_done === e.last) else begin
                        bad++;
                        $error("FAIL frame_done: got %b, required %b", frame_done, e.last);
                    end
                end
                if (frame_done === 1'b1) fd_cyc.push_back(cnt);
            end else begin
                total++;
                assert (valid === 1'b0 && frame_done === 1'b0) else begin
                    bad++;
                    $error("FAIL idle_flags: valid=%b frame_done=%b, required 0/0", valid, frame_done);
                end
                total++;
                assert (conv_out === last_exp) else begin
                    bad++;
                    $error("FAIL hold: conv_out=%0d, required %0d", $signed(conv_out), $signed(last_exp));
                end
            end
        end
    end

    task automatic drive_pixel(input int p);
        @(negedge clk);
        pixel_in    = 8'(p);
        pixel_valid = 1'b1;
        coef_we     = 1'b0;
        img[mrow][mcol] = p;
        if (mrow >= 2 && mcol >= 2) begin
            exp_t e;
            int s = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += img[mrow-2+r][mcol-2+c] * kern[3*r+c];
            e.val  = 32'(s);
            e.last = (mrow == H-1) && (mcol == W-1);
            e.cyc  = cnt;
            sbq.push_back(e);
        end
        if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            coef_we     = 1'b0;
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        pixel_valid = 1'b0;
        coef_we     = 1'b1;
        coef_addr   = 4'(addr);
        coef_data   = 8'(data);
        if (addr <= 8) kern[addr] = data;
    endtask

    task automatic frame(input int gap);
        for (int p = 0; p < W*H; p++) begin
            drive_pixel(p);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset(input bit pv_during);
        @(negedge clk);
        rst         = 1'b1;
        pixel_valid = pv_during;
        pixel_in    = 8'd99;
        coef_we     = 1'b0;
        @(posedge clk);
        #1;
        sbq.delete();
        last_exp = '0;
        mrow = 0;
        mcol = 0;
        for (int k = 0; k < 9; k++) kern[k] = 1;
        @(negedge clk);
        rst         = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic drain(input int exp_n, input string tag);
        int guard = 0;
        idle(1);
        while (sbq.size() > 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL %s_drain: %0d results outstanding, required 0", tag, sbq.size());
        end
        total++;
        assert (nvalid == exp_n) else begin
            bad++;
            $error("FAIL %s_count: %0d valids, required %0d", tag, nvalid, exp_n);
        end
        $display("%s: %0d valids observed", tag, nvalid);
    endtask

    initial begin
        for (int k = 0; k < 9; k++) kern[k] = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        total++;
        assert (conv_out === 32'd0 && valid === 1'b0 && frame_done === 1'b0) else begin
            bad++;
            $error("FAIL reset_state: conv_out=%h valid=%b frame_done=%b, required 0/0/0", conv_out, valid, frame_done);
        end
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // 1: box kernel, consecutive pixels
        nvalid = 0; fd_cyc.delete();
        frame(0);
        drain(9, "box");
        total++;
        assert (fd_cyc.size() == 1) else begin
            bad++;
            $error("FAIL box_frame_done: %0d pulses, required 1", fd_cyc.size());
        end

        // 2: identity-centre kernel, address 9 write ignored
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 1 : 0);
        write_coef(9, 5);
        idle(1);
        nvalid = 0;
        frame(0);
        drain(9, "center");

        // 3: extreme values
        for (int k = 0; k < 9; k++) write_coef(k, -128);
        idle(1);
        nvalid = 0;
        for (int p = 0; p < W*H; p++) drive_pixel(255);
        drain(9, "extreme");

        // 4: box kernel restored by reset, pixel every other cycle
        do_reset(1'b0);
        nvalid = 0;
        frame(1);
        drain(9, "gapped");

        // 5: partial frame, reset (with pixel_valid high), full frame
        nvalid = 0;
        for (int p = 0; p < 8; p++) drive_pixel(p);
        do_reset(1'b1);
        frame(0);
        drain(9, "midreset");

        // 6: two back-to-back frames
        nvalid = 0; fd_cyc.delete();
        frame(0);
        frame(0);
        drain(18, "b2b");
        total++;
        assert (fd_cyc.size() == 2) else begin
            bad++;
            $error("FAIL b2b_frame_done: %0d pulses, required 2", fd_cyc.size());
        end
        if (fd_cyc.size() == 2) begin
            total++;
            assert (fd_cyc[1] - fd_cyc[0] == 25) else begin
                bad++;
                $error("FAIL b2b_spacing: %0d clocks, required 25", fd_cyc[1] - fd_cyc[0]);
            end
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming 3x3 convolution engine for the CNN datapath. Accepts a raster-scan pixel stream (one 8-bit unsigned pixel per accepted cycle) and a host-loadable signed 3x3 kernel. Uses two line buffers and a 3x3 window register to emit one 32-bit signed result per valid window ("valid" padding). Sits between the image-feeding controller, which supplies `pixel_in`, and the feature-map collector, which consumes `conv_out` / `valid`.

## Interface
- `IMG_W`, 5, image width in pixels (≥3)
- `IMG_H`, 5, image height in pixels (≥3)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pixel_in`  in  8  unsigned pixel, raster order, row 0 first
- `pixel_valid`  in  1  pixel_in sampled on this edge when high
- `coef_we`  in  1  kernel coefficient write strobe
- `coef_addr`  in  4  coefficient index k = 3*r + c
- `coef_data`  in  8  signed coefficient
- `conv_out`  out  32  signed convolution result
- `valid`  out  1  one-cycle strobe, conv_out holds a new result
- `frame_done`  out  1  one-cycle pulse coincident with last valid of a frame

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel. `col` wraps to 0 and increments `row`. After pixel (IMG_H-1, IMG_W-1), both wrap to 0 and the next pixel starts a new frame.
- Line buffers: two IMG_W-deep shift registers holding rows row-1 and row-2. They advance only on accepted pixels.
- Window: 3x3 register, shifted left one column per accepted pixel.
  - New right column = {linebuf2 out, linebuf1 out, pixel_in}, top to bottom.
  - Window element w[r][c]: r=0 is the oldest row; c=0 is the oldest column.
- Window complete when the accepted pixel has row≥2 and col≥2. This gives (IMG_H-2)*(IMG_W-2) results per frame, in raster order.
- Arithmetic is correlation, with no kernel flip: sum over r,c of w[r][c] * coef[3r+c].
  - Pixel zero-extended to 9-bit signed; 9x8 product is 17 bits signed.
  - 9-term sum is 21 bits signed, sign-extended to 32 bits.
  - No saturation or rounding.
- Kernel store: 9 signed 8-bit registers.
  - Reset value: all +1 (box sum).
  - `coef_we` with `coef_addr` ≤ 8 writes on that edge. Addresses 9..15 are ignored.
  - Writes take effect for any window summed on a later edge. No interlock with a frame in progress.
- Line buffer and window contents are not cleared by reset or at frame wrap. The row/col gating guarantees stale data never reaches an output.

## Timing
- Two-stage pipeline:
  - Stage 1 (edge E): pixel accepted, window/counters updated, window-complete flag registered.
  - Stage 2 (edge E+1): products and sum registered into `conv_out`; `valid` <= stage-1 flag.
- Latency: `valid` is high during the cycle following edge E+1, i.e. 2 clocks after the completing pixel is sampled.
- `valid` is high for exactly one cycle per completed window. No duplicate outputs when `pixel_valid` has gaps.
- `conv_out` holds its last value while `valid` is low.
- Full throughput: one pixel per cycle, no backpressure. The consumer must accept every `valid` strobe.
- `frame_done` asserts in the same cycle as the `valid` for window (IMG_H-1, IMG_W-1).
- Back-to-back frames need no idle cycles. The first pixel of frame N+1 may be accepted on the edge after the last pixel of frame N.
- Reset values: `conv_out`=0, `valid`=0, `frame_done`=0, `row`=`col`=0, kernel all +1, pipeline flags cleared.
- Reset mid-frame: in-flight results are dropped (no `valid` in the cycle after `rst`). The next accepted pixel is (0,0).
- `pixel_valid` and `coef_we` are ignored on any edge where `rst` is high.
- Simultaneous `coef_we` and completing pixel on edge E: the new coefficient is used for that window, because the sum is formed at E+1.

## Test plan
- Reset kernel, pixels 0..24 on consecutive cycles, IMG 5x5:
  - Results 54, 63, 72, 99, 108, 117, 144, 153, 162.
  - First `valid` 2 clocks after pixel 12 is sampled.
  - `frame_done` high only with 162.
- Load coef[4]=1 and all others 0 (including a write to addr 9 = 5, which must be ignored), then pixels 0..24:
  - Results 6, 7, 8, 11, 12, 13, 16, 17, 18.
- All coefs = -128, all pixels 255:
  - Every result is -293760 (0xFFFB8480); 9 valids.
- Reset kernel, pixels 0..24 with `pixel_valid` high every other cycle:
  - Same 9 values as scenario 1, each `valid` exactly one cycle, no extras.
- Feed pixels 0..7, assert `rst` for one cycle, then a full frame 0..24:
  - No `valid` before pixel 12 of the new frame.
  - Exactly the 9 values of scenario 1.
- Two back-to-back frames 0..24, 0..24, no gap:
  - 18 valids, the second 9 identical to the first.
  - Two `frame_done` pulses, 25 clocks apart.
